// File: rtl/flasher_bar_arbiter_if.sv
// Bus between the LED-bar arbiter and its pattern engines.
// The master side belongs to the engines and the slave side to the arbiter.
interface flasher_bar_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LED_W   = 16
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ*LED_W-1:0] led_in;
  logic [NUM_REQ-1:0]       grant;
  logic                     step_en;
  logic [LED_W-1:0]         LED;
  logic [OW-1:0]            owner;
  logic                     busy;

  modport master (
    output req, done, led_in,
    input  grant, step_en, LED, owner, busy
  );

  modport slave (
    input  req, done, led_in,
    output grant, step_en, LED, owner, busy
  );
endinterface

// File: rtl/flasher_bar_arbiter.sv
// Round-robin arbiter that shares one LED bar between several pattern engines.
// It paces the owner with step_en, limits hold time while others wait, and
// blanks the bar for BLANK_CYC cycles between owners.
// Optional build macro FLASHER_ARB_PRIO0_EN makes engine 0 an urgent requester
// that preempts other owners and is never preempted itself.
module flasher_bar_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LED_W     = 16,
  parameter int TICK_DIV  = 8,
  parameter int MAX_HOLD  = 256,
  parameter int BLANK_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  flasher_bar_arbiter_if.slave bus
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]      HOLD_SAT   = HW'(MAX_HOLD);
  localparam logic [BW-1:0]      BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [OW-1:0]      OWN_LAST   = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BLANK} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               step_en_q;
  logic [LED_W-1:0]   led_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      rr_q;
  logic               busy_q;
  logic [TW-1:0]      tick_q;
  logic [HW-1:0]      hold_q;
  logic [BW-1:0]      blank_q;

  logic [OW-1:0]      sel_d;
  logic               any_req_d;
  logic               others_d;
  logic               release_d;
  logic [OW-1:0]      rr_d;
  int                 idx;

  // Pick the first requester at or after the round-robin pointer.
  always_comb begin
    sel_d     = rr_q;
    any_req_d = 1'b0;
    idx       = 0;
    // Walk downward so the nearest requester is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (bus.req[idx]) begin
        sel_d     = OW'(idx);
        any_req_d = 1'b1;
      end
    end
`ifdef FLASHER_ARB_PRIO0_EN
    if (bus.req[0]) begin
      sel_d = '0;
    end
`endif
  end

  // Decide whether the current owner gives up the bar at this edge.
  always_comb begin
    others_d  = |(bus.req & ~(ONE_HOT0 << owner_q));
    rr_d      = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
`ifdef FLASHER_ARB_PRIO0_EN
    // Engine 0 as owner ignores the hold limit; any other owner yields to it at once.
    release_d = bus.done[owner_q] || !bus.req[owner_q] ||
                ((owner_q != '0) && (bus.req[0] || ((hold_q == HOLD_SAT) && others_d)));
`else
    release_d = bus.done[owner_q] || !bus.req[owner_q] ||
                ((hold_q == HOLD_SAT) && others_d);
`endif
  end

  // Arbitration FSM with registered grant, pacing, LED and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      step_en_q <= 1'b0;
      led_q     <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      busy_q    <= 1'b0;
      tick_q    <= '0;
      hold_q    <= '0;
      blank_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          led_q     <= '0;
          step_en_q <= 1'b0;
          if (any_req_d) begin
            state_q        <= S_GRANT;
            grant_q        <= '0;
            grant_q[sel_d] <= 1'b1;
            owner_q        <= sel_d;
            busy_q         <= 1'b1;
            tick_q         <= '0;
            hold_q         <= '0;
          end
        end
        S_GRANT: begin
          if (release_d) begin
            state_q   <= S_BLANK;
            grant_q   <= '0;
            step_en_q <= 1'b0;
            led_q     <= '0;
            rr_q      <= rr_d;
            blank_q   <= '0;
          end else begin
            led_q     <= bus.led_in[int'(owner_q)*LED_W +: LED_W];
            step_en_q <= (tick_q == TICK_LAST);
            tick_q    <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            if (hold_q != HOLD_SAT) begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        S_BLANK: begin
          if (blank_q == BLANK_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            blank_q <= blank_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.step_en = step_en_q;
  assign bus.LED     = led_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_flasher_bar_arbiter.sv
// Directed bench for flasher_bar_arbiter: a per-cycle vector table plus
// hand-written multi-cycle sequences for handover, hold limit and preemption.
module tb_flasher_bar_arbiter;

  logic clk;
  logic rst;
  logic [15:0] led0;
  int checks;
  int errors;

  flasher_bar_arbiter_if #(.NUM_REQ(4), .LED_W(16)) ifc ();

  flasher_bar_arbiter #(
    .NUM_REQ(4), .LED_W(16), .TICK_DIV(8), .MAX_HOLD(256), .BLANK_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifc.led_in = {16'h4444, 16'h3333, 16'h2222, led0};

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  done;
    logic [15:0] led;
    logic [3:0]  grant;
    logic [15:0] led_exp;
    logic [1:0]  owner;
    logic        busy;
    logic        step;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] dn,
                              input logic [15:0] ld, input logic [3:0] g,
                              input logic [15:0] le, input logic [1:0] ow,
                              input logic b, input logic s);
    vec_t v;
    v.req = rq; v.done = dn; v.led = ld; v.grant = g;
    v.led_exp = le; v.owner = ow; v.busy = b; v.step = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req = '0;
    ifc.done = '0;
    led0 = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Count grant-free cycles after a release, and how many were busy / had LED lit.
  task automatic gap_measure(output int gap, output int blank, output int ledbad);
    gap = 0; blank = 0; ledbad = 0;
    while (ifc.grant == 4'b0000 && gap < 20) begin
      gap++;
      if (ifc.busy) blank++;
      if (ifc.LED != 16'h0000) ledbad++;
      step();
    end
  endtask

  // Steps until grant drops, continuing the count k.
  task automatic run_to_release(inout int k);
    while (ifc.grant != 4'b0000 && k < 600) begin
      step();
      k++;
    end
  endtask

  int gap, blank, ledbad, k, bad;
  logic [1:0] exp_seq [5];
  logic [1:0] cur;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifc.req = '0;
    ifc.done = '0;
    led0 = '0;

    //             req      done     led      grant    LED      own  busy step
    tbl[0]  = mk(4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd0, 1'b0, 1'b0);
    tbl[1]  = mk(4'b0001, 4'b0000, 16'hAAAA, 4'b0001, 16'h0000, 2'd0, 1'b1, 1'b0);
    tbl[2]  = mk(4'b0001, 4'b0000, 16'h1234, 4'b0001, 16'h1234, 2'd0, 1'b1, 1'b0);
    tbl[3]  = mk(4'b0001, 4'b0000, 16'h0F0F, 4'b0001, 16'h0F0F, 2'd0, 1'b1, 1'b0);
    tbl[4]  = mk(4'b0001, 4'b0000, 16'hF0F0, 4'b0001, 16'hF0F0, 2'd0, 1'b1, 1'b0);
    tbl[5]  = mk(4'b0001, 4'b0000, 16'h8001, 4'b0001, 16'h8001, 2'd0, 1'b1, 1'b0);
    tbl[6]  = mk(4'b0001, 4'b0000, 16'h7FFE, 4'b0001, 16'h7FFE, 2'd0, 1'b1, 1'b0);
    tbl[7]  = mk(4'b0001, 4'b0000, 16'h0000, 4'b0001, 16'h0000, 2'd0, 1'b1, 1'b0);
    tbl[8]  = mk(4'b0001, 4'b0000, 16'hFFFF, 4'b0001, 16'hFFFF, 2'd0, 1'b1, 1'b0);
    tbl[9]  = mk(4'b0001, 4'b0000, 16'h5555, 4'b0001, 16'h5555, 2'd0, 1'b1, 1'b1);
    tbl[10] = mk(4'b0001, 4'b0000, 16'h3C3C, 4'b0001, 16'h3C3C, 2'd0, 1'b1, 1'b0);
    tbl[11] = mk(4'b0001, 4'b1000, 16'hC3C3, 4'b0001, 16'hC3C3, 2'd0, 1'b1, 1'b0);
    tbl[12] = mk(4'b0000, 4'b0000, 16'hBEEF, 4'b0000, 16'h0000, 2'd0, 1'b1, 1'b0);
    tbl[13] = mk(4'b0000, 4'b0000, 16'hBEEF, 4'b0000, 16'h0000, 2'd0, 1'b1, 1'b0);
    tbl[14] = mk(4'b0000, 4'b0000, 16'hBEEF, 4'b0000, 16'h0000, 2'd0, 1'b1, 1'b0);
    tbl[15] = mk(4'b0000, 4'b0000, 16'hBEEF, 4'b0000, 16'h0000, 2'd0, 1'b1, 1'b0);
    tbl[16] = mk(4'b0000, 4'b0000, 16'hBEEF, 4'b0000, 16'h0000, 2'd0, 1'b0, 1'b0);
    tbl[17] = mk(4'b0010, 4'b0000, 16'h1111, 4'b0010, 16'h0000, 2'd1, 1'b1, 1'b0);
    tbl[18] = mk(4'b0010, 4'b0000, 16'h1111, 4'b0010, 16'h2222, 2'd1, 1'b1, 1'b0);
    tbl[19] = mk(4'b0010, 4'b0010, 16'h1111, 4'b0000, 16'h0000, 2'd1, 1'b1, 1'b0);
    tbl[20] = mk(4'b0000, 4'b0000, 16'h1111, 4'b0000, 16'h0000, 2'd1, 1'b1, 1'b0);
    tbl[21] = mk(4'b0000, 4'b0000, 16'h1111, 4'b0000, 16'h0000, 2'd1, 1'b1, 1'b0);
    tbl[22] = mk(4'b0000, 4'b0000, 16'h1111, 4'b0000, 16'h0000, 2'd1, 1'b1, 1'b0);
    tbl[23] = mk(4'b0000, 4'b0000, 16'h1111, 4'b0000, 16'h0000, 2'd1, 1'b0, 1'b0);

    // Reset state
    step();
    step();
    chk("rst_grant", ifc.grant, 4'b0000);
    chk("rst_step", ifc.step_en, 1'b0);
    chk("rst_led", ifc.LED, 16'h0000);
    chk("rst_owner", ifc.owner, 2'd0);
    chk("rst_busy", ifc.busy, 1'b0);
    rst = 1'b0;

    // Per-cycle vector table
    for (int i = 0; i < 24; i++) begin
      ifc.req = tbl[i].req;
      ifc.done = tbl[i].done;
      led0 = tbl[i].led;
      step();
      chk($sformatf("v%0d_grant", i), ifc.grant, tbl[i].grant);
      chk($sformatf("v%0d_led", i), ifc.LED, tbl[i].led_exp);
      chk($sformatf("v%0d_owner", i), ifc.owner, tbl[i].owner);
      chk($sformatf("v%0d_busy", i), ifc.busy, tbl[i].busy);
      chk($sformatf("v%0d_step", i), ifc.step_en, tbl[i].step);
    end

    // Pointer now at 2: engines 0 and 3 request together
    ifc.done = '0;
    ifc.req = 4'b1001;
    step();
`ifdef FLASHER_ARB_PRIO0_EN
    chk("rr_wrap_owner", ifc.owner, 2'd0);
    chk("rr_wrap_grant", ifc.grant, 4'b0001);
`else
    chk("rr_wrap_owner", ifc.owner, 2'd3);
    chk("rr_wrap_grant", ifc.grant, 4'b1000);
`endif

    // All four request; each owner pulses done after 20 cycles
`ifdef FLASHER_ARB_PRIO0_EN
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd0; exp_seq[2] = 2'd0; exp_seq[3] = 2'd0; exp_seq[4] = 2'd0;
`else
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
`endif
    do_reset();
    ifc.req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("rr%0d_owner", n), ifc.owner, exp_seq[n]);
      chk($sformatf("rr%0d_grant", n), ifc.grant, 4'b0001 << exp_seq[n]);
      repeat (19) step();
      cur = ifc.owner;
      ifc.done = 4'b0001 << cur;
      step();
      ifc.done = '0;
      gap_measure(gap, blank, ledbad);
      chk($sformatf("rr%0d_gap", n), gap, 5);
      chk($sformatf("rr%0d_blank", n), blank, 4);
      chk($sformatf("rr%0d_ledoff", n), ledbad, 0);
    end

    // Lone owner keeps the bar well past the hold limit
    do_reset();
    ifc.req = 4'b0010;
    step();
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (ifc.grant != 4'b0010) bad++;
      step();
    end
    chk("lone_hold_bad_cycles", bad, 0);
    chk("lone_hold_grant", ifc.grant, 4'b0010);

    // Owner 1, engine 2 joins at hold=100: release at the hold limit
    do_reset();
    ifc.req = 4'b0010;
    step();
    k = 0;
    repeat (100) begin step(); k++; end
    ifc.req = 4'b0110;
    run_to_release(k);
    chk("maxhold_release_cycle", k, 257);
    gap_measure(gap, blank, ledbad);
    chk("maxhold_blank", blank, 4);
    chk("maxhold_gap", gap, 5);
    chk("maxhold_next_grant", ifc.grant, 4'b0100);
    chk("maxhold_next_owner", ifc.owner, 2'd2);
    step();
    chk("maxhold_next_led", ifc.LED, 16'h3333);

    // Owner 2 at hold=10 when engine 0 requests
    do_reset();
    ifc.req = 4'b0100;
    step();
    k = 0;
    repeat (10) begin step(); k++; end
    ifc.req = 4'b0101;
    run_to_release(k);
`ifdef FLASHER_ARB_PRIO0_EN
    chk("prio0_release_cycle", k, 11);
`else
    chk("prio0_release_cycle", k, 257);
`endif
    gap_measure(gap, blank, ledbad);
    chk("prio0_blank", blank, 4);
    chk("prio0_next_grant", ifc.grant, 4'b0001);

    // Reset in the middle of a grant drops everything at the next edge
    rst = 1'b1;
    step();
    chk("midrst_grant", ifc.grant, 4'b0000);
    chk("midrst_busy", ifc.busy, 1'b0);
    chk("midrst_owner", ifc.owner, 2'd0);
    rst = 1'b0;
    ifc.req = 4'b0000;
    step();
    chk("midrst_idle_busy", ifc.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
